load_store_unit: RTL and testbench

Sequences pipeline load/store requests onto the byte-addressed data memory (port names addr/dataW/dataR/memR/memW, little-endian, always touches 4 consecutive bytes). Sits between the execute/memory pipeline stage and the data memory. Decodes RISC-V width/sign from funct3, checks alignment and range, performs read-modify-write for sub-word stores, and sign/zero-extends loads. Returns one response per accepted request.

---
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer between the memory pipeline stage and a byte-addressed,
// little-endian, 4-byte-wide data memory; read-modify-write for SB/SH.
module load_store_unit #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_dataW,
    output logic              mem_memR,
    output logic              mem_memW,
    input  logic [31:0]       mem_dataR
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    // highest address whose 4-byte access still fits in the memory
    localparam logic [ADDR_W-1:0] ADDR_MAX = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t      state, state_nx;
    logic        rdy_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [15:0] wdata_q;
    logic        accept;
    logic        f3_bad, misal, range_bad, req_err;
    logic [31:0] load_ext;
    logic [31:0] store_merge;

    assign req_ready  = rdy_q && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign mem_memR   = (state == READ);
    assign mem_memW   = (state == WRITE);
    assign resp_valid = (state == RESP);

    always_comb begin
        f3_bad = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
            3'b100, 3'b101:         f3_bad = req_we;
            default:                f3_bad = 1'b1;
        endcase
        misal     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        range_bad = (req_addr[31:ADDR_W] != '0) || (req_addr[ADDR_W-1:0] > ADDR_MAX);
        req_err   = f3_bad || misal || range_bad;
    end

    always_comb begin
        load_ext = mem_dataR;
        case (f3_q[1:0])
            2'b00:   load_ext = {{24{~f3_q[2] & mem_dataR[7]}}, mem_dataR[7:0]};
            2'b01:   load_ext = {{16{~f3_q[2] & mem_dataR[15]}}, mem_dataR[15:0]};
            default: load_ext = mem_dataR;
        endcase
        store_merge = f3_q[0] ? {mem_dataR[31:16], wdata_q[15:0]}
                              : {mem_dataR[31:8], wdata_q[7:0]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nx = RESP;
                    else if (req_we && (req_funct3[1:0] == 2'b10))
                        state_nx = WRITE;
                    else
                        state_nx = READ;
                end
            end
            READ:    state_nx = we_q ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nx;
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            f3_q       <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_dataW  <= '0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                f3_q       <= req_funct3;
                wdata_q    <= req_wdata[15:0];
                resp_err   <= req_err;
                resp_rdata <= '0;
                if (!req_err) begin
                    mem_addr <= req_addr[ADDR_W-1:0];
                    if (req_we && (req_funct3[1:0] == 2'b10))
                        mem_dataW <= req_wdata;
                end
            end
            // the read word is consumed here, so WRITE drives a registered merge
            if (state == READ) begin
                if (we_q)
                    mem_dataW <= store_merge;
                else
                    resp_rdata <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte memory.
module tb_load_store_unit;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = '0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_dataW;
    logic              mem_memR;
    logic              mem_memW;
    logic [31:0]       mem_dataR;

    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_dataW(mem_dataW), .mem_memR(mem_memR),
        .mem_memW(mem_memW), .mem_dataR(mem_dataR)
    );

    always #5 clk = ~clk;

    logic [7:0] m [0:4095];
    assign mem_dataR = {m[mem_addr + 12'd3], m[mem_addr + 12'd2], m[mem_addr + 12'd1], m[mem_addr]};

    always @(posedge clk) begin
        if (mem_memW) begin
            m[mem_addr]         = mem_dataW[7:0];
            m[mem_addr + 12'd1] = mem_dataW[15:8];
            m[mem_addr + 12'd2] = mem_dataW[23:16];
            m[mem_addr + 12'd3] = mem_dataW[31:24];
        end
    end

    int          rd_hi = 0, rd_rise = 0, wr_hi = 0, resp_cnt = 0;
    logic        memr_prev = 1'b0;
    logic [31:0] last_wdata = '0;

    always @(negedge clk) begin
        if (mem_memR) rd_hi++;
        if (mem_memR && !memr_prev) rd_rise++;
        memr_prev = mem_memR;
        if (mem_memW) begin
            wr_hi++;
            last_wdata = mem_dataW;
        end
        if (resp_valid) resp_cnt++;
    end

    function automatic logic [31:0] mword(input int a);
        return {m[a+3], m[a+2], m[a+1], m[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_reads, input int exp_writes);
        int r0 = rd_hi;
        int w0 = wr_hi;
        int lat = 0;
        chk({tag, ".ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            if (resp_valid) lat = k;
            else tick();
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
        chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, ".reads"}, 32'(rd_hi - r0), 32'(exp_reads));
        chk({tag, ".writes"}, 32'(wr_hi - w0), 32'(exp_writes));
        tick();
        chk({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic        b_we [3];
    logic [2:0]  b_f3 [3];
    logic [31:0] b_ad [3];
    logic [31:0] b_wd [3];
    logic [31:0] b_ex [3];

    initial begin
        int idx, got, r0, h0, w0, c0;
        logic accepted;
        for (int i = 0; i < 4096; i++) m[i] = 8'h00;
        {m[16'h013], m[16'h012], m[16'h011], m[16'h010]} = 32'h12345678;
        m[12'h021] = 8'h80;
        {m[16'h043], m[16'h042], m[16'h041], m[16'h040]} = 32'h11223344;
        {m[16'h053], m[16'h052], m[16'h051], m[16'h050]} = 32'hCAFEF00D;
        {m[16'h083], m[16'h082], m[16'h081], m[16'h080]} = 32'h55555555;
        {m[16'hFFF], m[16'hFFE], m[16'hFFD], m[16'hFFC]} = 32'h04030201;

        #2;
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.memR", 32'(mem_memR), 32'd0);
        chk("rst.memW", 32'(mem_memW), 32'd0);
        chk("rst.addr", 32'(mem_addr), 32'd0);
        chk("rst.dataW", mem_dataW, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst.ready", 32'(req_ready), 32'd1);

        do_req("lw010", 1'b0, 3'b010, 32'h010, 32'h0, 2, 32'h12345678, 1'b0, 1, 0);
        do_req("lb021", 1'b0, 3'b000, 32'h021, 32'h0, 2, 32'hFFFFFF80, 1'b0, 1, 0);
        do_req("lbu021", 1'b0, 3'b100, 32'h021, 32'h0, 2, 32'h00000080, 1'b0, 1, 0);
        do_req("lw_ffc", 1'b0, 3'b010, 32'hFFC, 32'h0, 2, 32'h04030201, 1'b0, 1, 0);

        do_req("sb040", 1'b1, 3'b000, 32'h040, 32'hAABBCCDD, 3, 32'h0, 1'b0, 1, 1);
        chk("sb040.dataW", last_wdata, 32'h112233DD);
        do_req("lw040", 1'b0, 3'b010, 32'h040, 32'h0, 2, 32'h112233DD, 1'b0, 1, 0);

        do_req("err_lh003", 1'b0, 3'b001, 32'h003, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        do_req("err_sw_ffe", 1'b1, 3'b010, 32'hFFE, 32'h12345678, 1, 32'h0, 1'b1, 0, 0);
        do_req("err_sb_f3_100", 1'b1, 3'b100, 32'h040, 32'h99999999, 1, 32'h0, 1'b1, 0, 0);
        do_req("err_lw_1000", 1'b0, 3'b010, 32'h1000, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        do_req("err_f3_011", 1'b0, 3'b011, 32'h010, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        chk("err.mem040_kept", mword(12'h040), 32'h112233DD);

        b_we[0] = 1'b0; b_f3[0] = 3'b010; b_ad[0] = 32'h010; b_wd[0] = 32'h0;        b_ex[0] = 32'h12345678;
        b_we[1] = 1'b0; b_f3[1] = 3'b010; b_ad[1] = 32'h040; b_wd[1] = 32'h0;        b_ex[1] = 32'h112233DD;
        b_we[2] = 1'b1; b_f3[2] = 3'b001; b_ad[2] = 32'h050; b_wd[2] = 32'h0000BEEF; b_ex[2] = 32'h0;
        idx = 0; got = 0; r0 = rd_rise; h0 = rd_hi;
        req_valid = 1'b1; req_we = b_we[0]; req_funct3 = b_f3[0]; req_addr = b_ad[0]; req_wdata = b_wd[0];
        for (int c = 0; c < 40 && got < 3; c++) begin
            accepted = req_valid && req_ready;
            tick();
            if (accepted) begin
                idx++;
                if (idx < 3) begin
                    req_we = b_we[idx]; req_funct3 = b_f3[idx]; req_addr = b_ad[idx]; req_wdata = b_wd[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (resp_valid) begin
                chk($sformatf("b2b.rdata%0d", got), resp_rdata, b_ex[got]);
                chk($sformatf("b2b.busy%0d", got), 32'(req_ready), 32'd0);
                got++;
            end
        end
        chk("b2b.responses", 32'(got), 32'd3);
        chk("b2b.read_pulses", 32'(rd_rise - r0), 32'd3);
        chk("b2b.read_cycles", 32'(rd_hi - h0), 32'd3);
        tick();
        do_req("lw050", 1'b0, 3'b010, 32'h050, 32'h0, 2, 32'hCAFEBEEF, 1'b0, 1, 0);

        w0 = wr_hi; c0 = resp_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h080; req_wdata = 32'hDEADBEEF;
        tick();
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        chk("rstw.in_write", 32'(mem_memW), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw.memW", 32'(mem_memW), 32'd0);
        chk("rstw.addr", 32'(mem_addr), 32'd0);
        chk("rstw.dataW", mem_dataW, 32'd0);
        chk("rstw.ready", 32'(req_ready), 32'd0);
        chk("rstw.resp_valid", 32'(resp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("rstw.no_resp", 32'(resp_cnt - c0), 32'd0);
        chk("rstw.no_write", 32'(wr_hi - w0), 32'd0);
        chk("rstw.mem080", mword(12'h080), 32'h55555555);
        do_req("lw080", 1'b0, 3'b010, 32'h080, 32'h0, 2, 32'h55555555, 1'b0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
